// File: rtl/ahb_mem_slave_p.sv
// rtl/ahb_mem_slave_p.sv - AHB-Lite slave in front of a synchronous word-wide memory
// Wait states, ERROR responses and write-to-read byte forwarding.
module ahb_mem_slave_p #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_STATES = 0
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       HSEL,
  input  logic [ADDR_W-1:0]          HADDR,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
  input  logic [2:0]                 HBURST,
  input  logic [1:0]                 HTRANS,
  input  logic [DATA_W-1:0]          HWDATA,
  input  logic                       HREADY,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  output logic [DATA_W-1:0]          HRDATA,
  output logic [$clog2(DEPTH)-1:0]   mem_addr,
  output logic [$clog2(DEPTH)-1:0]   mem_waddr,
  output logic                       mem_we,
  output logic [DATA_W/8-1:0]        mem_wstrb,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_re,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int AW     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * NB);
  localparam logic [2:0]      MAX_SIZE  = 3'(LANE_W);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

  state_t            state;
  logic [2:0]        wcnt;
  logic              wr_r, rd_r;
  logic [AW-1:0]     word_r;
  logic [NB-1:0]     strb_r;
  logic [NB-1:0]     fwd_strb;
  logic [DATA_W-1:0] fwd_data;

  logic [ADDR_W:0]   off;
  logic [LANE_W-1:0] lane, size_mask;
  logic [AW-1:0]     acc_word;
  logic [NB-1:0]     acc_strb;
  logic              ready_state, accept, acc_err, acc_good, hit, rd_phase;
  logic              unused_bits;

  assign unused_bits = ^{HTRANS[0], HBURST};

  // Offset is one bit wider so addresses below BASE_ADDR wrap to a huge value and fail the range check.
  assign off       = {1'b0, HADDR} - {1'b0, BASE_ADDR};
  assign lane      = HADDR[LANE_W-1:0];
  assign size_mask = LANE_W'((32'd1 << HSIZE) - 32'd1);
  assign acc_word  = off[LANE_W +: AW];
  assign acc_strb  = NB'(((32'd1 << (32'd1 << HSIZE)) - 32'd1) << lane);

  assign ready_state = (state == S_IDLE) || (state == S_LAST) || (state == S_ERR2);
  assign accept      = HSEL && HREADY && HTRANS[1] && ready_state;
  assign acc_err     = (off >= MEM_BYTES) || (HSIZE > MAX_SIZE) || (|(lane & size_mask));
  assign acc_good    = accept && !acc_err;

  // mem_addr serves the read issued this cycle; a write finishing in the same cycle uses mem_waddr.
  assign mem_re    = acc_good && !HWRITE;
  assign mem_we    = (state == S_LAST) && wr_r;
  assign mem_waddr = word_r;
  assign mem_addr  = mem_re ? acc_word : word_r;
  assign mem_wstrb = mem_we ? strb_r : '0;
  assign mem_wdata = HWDATA;
  assign hit       = mem_we && (word_r == acc_word);
  assign rd_phase  = rd_r && ((state == S_WAIT) || (state == S_LAST));

  always_comb begin
    HRDATA = '0;
    if (rd_phase) begin
      for (int b = 0; b < NB; b++)
        HRDATA[8*b +: 8] = fwd_strb[b] ? fwd_data[8*b +: 8] : mem_rdata[8*b +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      wcnt      <= 3'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      wr_r      <= 1'b0;
      rd_r      <= 1'b0;
      word_r    <= '0;
      strb_r    <= '0;
      fwd_strb  <= '0;
      fwd_data  <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (wcnt == 3'd0) begin
            state     <= S_LAST;
            HREADYOUT <= 1'b1;
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          wr_r      <= 1'b0;
          rd_r      <= 1'b0;
          if (accept && acc_err) begin
            state     <= S_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else if (accept) begin
            wr_r     <= HWRITE;
            rd_r     <= !HWRITE;
            word_r   <= acc_word;
            strb_r   <= acc_strb;
            fwd_strb <= (hit && !HWRITE) ? strb_r : '0;
            fwd_data <= HWDATA;
            if (WAIT_STATES > 0) begin
              state     <= S_WAIT;
              HREADYOUT <= 1'b0;
              wcnt      <= 3'(WAIT_STATES - 1);
            end else begin
              state <= S_LAST;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave_p.sv
// tb/tb_ahb_mem_slave_p.sv - randomized and directed bench for ahb_mem_slave_p
// Three instances (0, 3 and 5 wait states) share the bus signals; one is selected at a time.
module tb_ahb_mem_slave_p;

  typedef struct packed {
    bit        sel;
    bit [1:0]  trans;
    bit        wr;
    bit [2:0]  size;
    bit [2:0]  burst;
    bit [31:0] addr;
    bit [31:0] wdata;
  } xfer_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel [3];
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;

  logic        hro [3];
  logic        hresp [3];
  logic [31:0] hrd [3];
  logic [9:0]  maddr [3];
  logic [9:0]  mwaddr [3];
  logic        mwe [3];
  logic [3:0]  mstrb [3];
  logic [31:0] mwd [3];
  logic        mre [3];

  logic [31:0] ref_mem [3][1024];
  xfer_t       q[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cur     = 0;
  bit          chk_en  = 1'b0;
  bit          exp_ready, exp_resp, exp_we, exp_re, exp_rd_valid;
  logic [3:0]  exp_strb;
  logic [9:0]  exp_raddr;
  logic [31:0] exp_rdata;

  int          st_stall, st_err, st_we, st_re;
  logic [31:0] st_rd;
  logic [3:0]  st_strb;
  int          we_addr[$];

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] init_word(input int k, input int i);
    return 32'hC0DE_0000 + 32'(k) * 32'h1000 + 32'(i);
  endfunction

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
  endfunction

  function automatic bit is_err(input xfer_t x);
    return (x.addr >= 32'h1000) || (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0);
  endfunction

  function automatic logic [3:0] strb_of(input xfer_t x);
    logic [3:0] s = 4'b0;
    for (int b = 0; b < 4; b++)
      if (b >= int'(x.addr[1:0]) && b < int'(x.addr[1:0]) + (1 << x.size)) s[b] = 1'b1;
    return s;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] ram [1024];
    logic [31:0] rdq;
    ahb_mem_slave_p #(
      .DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(1024),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 5))
    ) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[g]), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(hro[g]),
      .HREADYOUT(hro[g]), .HRESP(hresp[g]), .HRDATA(hrd[g]), .mem_addr(maddr[g]),
      .mem_waddr(mwaddr[g]), .mem_we(mwe[g]), .mem_wstrb(mstrb[g]), .mem_wdata(mwd[g]),
      .mem_re(mre[g]), .mem_rdata(rdq)
    );
    initial for (int i = 0; i < 1024; i++) ram[i] = init_word(g, i);
    always @(posedge HCLK) begin
      if (mre[g]) rdq <= ram[maddr[g]];
      if (mwe[g])
        for (int b = 0; b < 4; b++)
          if (mstrb[g][b]) ram[mwaddr[g]][8*b +: 8] <= mwd[g][8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d t=%0t): got %h, expected %h", nm, cur, $time, act, exp);
    end
  endtask

  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("hreadyout", 32'(hro[cur]), 32'(exp_ready));
      chk("hresp", 32'(hresp[cur]), 32'(exp_resp));
      chk("mem_re", 32'(mre[cur]), 32'(exp_re));
      if (exp_re) chk("mem_addr", 32'(maddr[cur]), 32'(exp_raddr));
      chk("mem_we", 32'(mwe[cur]), 32'(exp_we));
      if (exp_we) chk("mem_wstrb", 32'(mstrb[cur]), 32'(exp_strb));
      chk("hrdata", hrd[cur], exp_rd_valid ? exp_rdata : 32'h0);
      if (!hro[cur] && !hresp[cur]) st_stall++;
      if (hresp[cur]) st_err++;
      if (mre[cur]) st_re++;
      if (mwe[cur]) begin
        st_we++;
        st_strb = mstrb[cur];
        we_addr.push_back(int'(mwaddr[cur]));
      end
      if (exp_rd_valid && exp_ready) st_rd = hrd[cur];
    end
  end

  task automatic clr_stats();
    st_stall = 0; st_err = 0; st_we = 0; st_re = 0; st_rd = 32'h0; st_strb = 4'h0;
    we_addr.delete();
  endtask

  function automatic xfer_t mk(input bit sel, input bit [1:0] tr, input bit wr,
                               input bit [2:0] sz, input bit [31:0] a, input bit [31:0] d);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz; x.burst = 3'b000; x.addr = a; x.wdata = d;
    return x;
  endfunction

  function automatic xfer_t rnd_x();
    xfer_t x;
    int r, w, ln;
    x.sel   = ($urandom_range(99) < 92);
    r       = int'($urandom_range(99));
    x.trans = (r < 10) ? 2'd0 : ((r < 20) ? 2'd1 : ((r < 60) ? 2'd2 : 2'd3));
    x.wr    = 1'($urandom_range(1));
    x.size  = ($urandom_range(99) < 5) ? 3'd3 : 3'($urandom_range(2));
    x.burst = 3'($urandom_range(7));
    w       = int'($urandom_range(15));
    ln      = int'($urandom_range(3));
    if (x.size <= 3'd2 && $urandom_range(9) != 0) ln = ln & ~((1 << x.size) - 1);
    x.addr  = 32'(w * 4 + ln);
    r       = int'($urandom_range(39));
    if (r == 0) x.addr = 32'h1000 + 32'($urandom_range(255));
    if (r == 1) x.addr = 32'hFFC;
    x.wdata = $urandom;
    return x;
  endfunction

  task automatic drive_ap(input int k, input xfer_t x);
    for (int i = 0; i < 3; i++) hsel[i] = (i == k) ? x.sel : 1'b0;
    HADDR = x.addr; HWRITE = x.wr; HSIZE = x.size; HBURST = x.burst; HTRANS = x.trans;
  endtask

  task automatic commit(input int k, input xfer_t x);
    logic [3:0] s = strb_of(x);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[k][x.addr[11:2]][8*b +: 8] = x.wdata[8*b +: 8];
  endtask

  // Transaction-level model: each accepted transfer owns a data phase of known length;
  // the next address phase is presented until that phase ends.
  task automatic run_q(input int k);
    xfer_t x, dpx;
    int len, pos;
    bit dgood, derr, rdy, fin;
    logic [31:0] rexp;
    q.push_back(mk(1'b0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0));
    q.push_back(mk(1'b0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0));
    dpx = mk(1'b0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0);
    dgood = 1'b0; derr = 1'b0; len = 1; pos = 0; rexp = 32'h0; fin = 1'b0;
    x = q.pop_front();
    cur = k;
    while (!fin) begin
      @(posedge HCLK); #1;
      drive_ap(k, x);
      HWDATA       = dpx.wdata;
      rdy          = derr ? (pos == 1) : (pos == len - 1);
      exp_ready    = rdy;
      exp_resp     = derr;
      exp_we       = rdy && dgood && dpx.wr;
      exp_strb     = strb_of(dpx);
      exp_rd_valid = dgood && !dpx.wr;
      exp_rdata    = rexp;
      exp_re       = 1'b0;
      exp_raddr    = x.addr[11:2];
      if (rdy) begin
        if (exp_we) commit(k, dpx);
        dpx    = x;
        derr   = x.sel && x.trans[1] && is_err(x);
        dgood  = x.sel && x.trans[1] && !derr;
        len    = dgood ? ws_of(k) + 1 : (derr ? 2 : 1);
        pos    = 0;
        exp_re = dgood && !x.wr;
        rexp   = ref_mem[k][x.addr[11:2]];
        if (q.size() == 0) fin = 1'b1;
        else x = q.pop_front();
      end else begin
        pos++;
      end
      chk_en = 1'b1;
    end
    @(negedge HCLK); #1;
    chk_en = 1'b0;
    for (int i = 0; i < 3; i++) hsel[i] = 1'b0;
    HTRANS = 2'd0;
  endtask

  initial begin
    HRESETn = 1'b0;
    for (int i = 0; i < 3; i++) hsel[i] = 1'b0;
    HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'd2; HBURST = 3'd0; HTRANS = 2'd0; HWDATA = 32'h0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 1024; i++) ref_mem[k][i] = init_word(k, i);

    @(negedge HCLK);
    for (int k = 0; k < 3; k++) begin
      cur = k;
      chk("rst_hreadyout", 32'(hro[k]), 32'h1);
      chk("rst_hresp", 32'(hresp[k]), 32'h0);
      chk("rst_hrdata", hrd[k], 32'h0);
      chk("rst_mem_we", 32'(mwe[k]), 32'h0);
      chk("rst_mem_re", 32'(mre[k]), 32'h0);
      chk("rst_mem_wstrb", 32'(mstrb[k]), 32'h0);
    end
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Write then back-to-back read of the same word: forwarded, no stalls.
    clr_stats();
    q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'h10, 32'hA5A5_1234));
    q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0));
    run_q(0);
    chk("fwd_rdata", st_rd, 32'hA5A5_1234);
    chk("fwd_stalls", 32'(st_stall), 32'd0);
    chk("fwd_we_count", 32'(st_we), 32'd1);
    chk("fwd_err", 32'(st_err), 32'd0);

    // Three wait states on a read of 0x20.
    clr_stats();
    q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0));
    run_q(1);
    chk("ws3_stalls", 32'(st_stall), 32'd3);
    chk("ws3_rdata", st_rd, 32'hC0DE_1008);

    // Out of range access: two ERROR cycles, no memory traffic.
    clr_stats();
    q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h1000, 32'h0));
    run_q(0);
    chk("oor_err_cycles", 32'(st_err), 32'd2);
    chk("oor_mem_access", 32'(st_we + st_re), 32'd0);

    // Byte write into lane 3, misaligned halfword, then word read back.
    clr_stats();
    q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd0, 32'h13, 32'hEF00_0000));
    run_q(0);
    chk("byte_strb", 32'(st_strb), 32'h8);
    clr_stats();
    q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd1, 32'h11, 32'h0));
    q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0));
    run_q(0);
    chk("half_mis_err", 32'(st_err), 32'd2);
    chk("byte_merge_rd", st_rd, 32'hEFA5_1234);

    // INCR4 write with a BUSY beat between beats 2 and 3.
    clr_stats();
    q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'h0, 32'h1111_0000));
    q.push_back(mk(1'b1, 2'd3, 1'b1, 3'd2, 32'h4, 32'h2222_0001));
    q.push_back(mk(1'b1, 2'd1, 1'b1, 3'd2, 32'h8, 32'h0BAD_0BAD));
    q.push_back(mk(1'b1, 2'd3, 1'b1, 3'd2, 32'h8, 32'h3333_0002));
    q.push_back(mk(1'b1, 2'd3, 1'b1, 3'd2, 32'hC, 32'h4444_0003));
    for (int i = 0; i < 5; i++) q[i].burst = 3'b011;
    run_q(0);
    chk("burst_we_count", 32'(st_we), 32'd4);
    for (int i = 0; i < 4 && i < we_addr.size(); i++) chk("burst_word_addr", 32'(we_addr[i]), 32'(i));

    // Reset in the second WAIT cycle of a five-wait-state write.
    cur = 2;
    @(posedge HCLK); #1;
    drive_ap(2, mk(1'b1, 2'd2, 1'b1, 3'd2, 32'h40, 32'h0));
    @(posedge HCLK); #1;
    drive_ap(2, mk(1'b1, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0));
    HWDATA = 32'hDEAD_BEEF;
    @(posedge HCLK); #2;
    chk("pre_rst_stall", 32'(hro[2]), 32'h0);
    HRESETn = 1'b0;
    #1;
    chk("rst_mid_hreadyout", 32'(hro[2]), 32'h1);
    chk("rst_mid_hresp", 32'(hresp[2]), 32'h0);
    chk("rst_mid_mem_we", 32'(mwe[2]), 32'h0);
    for (int i = 0; i < 3; i++) hsel[i] = 1'b0;
    @(posedge HCLK); #1 HRESETn = 1'b1;
    clr_stats();
    for (int c = 0; c < 8; c++) begin
      @(negedge HCLK);
      if (mwe[2]) st_we++;
    end
    chk("post_rst_no_we", 32'(st_we), 32'd0);
    clr_stats();
    q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h0));
    run_q(2);
    chk("post_rst_rdata", st_rd, 32'hC0DE_2010);

    // Randomized traffic on each instance.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 150; i++) q.push_back(rnd_x());
      run_q(k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
